// File: rtl/riscv_str_ops_arb_if.sv
// Bus bundle for the two-requester string-op arbiter: requester ports plus the
// string-op unit side. slave = arbiter, master = requesters/unit environment.
interface riscv_str_ops_arb_if #(
  parameter int STR_OP_WIDTH = 2
);
  logic                    req0_valid_i, req1_valid_i;
  logic [STR_OP_WIDTH-1:0] req0_op_i, req1_op_i;
  logic [31:0]             req0_operand_i, req1_operand_i;
  logic                    req0_gnt_o, req1_gnt_o;
  logic                    req0_rvalid_o, req1_rvalid_o;
  logic [31:0]             req0_rdata_o, req1_rdata_o;
  logic                    req0_err_o, req1_err_o;
  logic                    req0_rready_i, req1_rready_i;
  logic                    unit_enable_o;
  logic [STR_OP_WIDTH-1:0] unit_operator_o;
  logic [31:0]             unit_operand_o;
  logic [31:0]             unit_result_i;
  logic                    unit_ready_i;
  logic                    unit_ex_ready_o;
  logic                    busy_o;

  modport slave (
    input  req0_valid_i, req1_valid_i, req0_op_i, req1_op_i,
           req0_operand_i, req1_operand_i, req0_rready_i, req1_rready_i,
           unit_result_i, unit_ready_i,
    output req0_gnt_o, req1_gnt_o, req0_rvalid_o, req1_rvalid_o,
           req0_rdata_o, req1_rdata_o, req0_err_o, req1_err_o,
           unit_enable_o, unit_operator_o, unit_operand_o, unit_ex_ready_o, busy_o
  );

  modport master (
    output req0_valid_i, req1_valid_i, req0_op_i, req1_op_i,
           req0_operand_i, req1_operand_i, req0_rready_i, req1_rready_i,
           unit_result_i, unit_ready_i,
    input  req0_gnt_o, req1_gnt_o, req0_rvalid_o, req1_rvalid_o,
           req0_rdata_o, req1_rdata_o, req0_err_o, req1_err_o,
           unit_enable_o, unit_operator_o, unit_operand_o, unit_ex_ready_o, busy_o
  );
endinterface

// File: rtl/riscv_str_ops_arb.sv
// Round-robin arbiter sharing one string-op unit between two requesters,
// with a bounded wait on the unit and a held response until accepted.
module riscv_str_ops_arb #(
  parameter int STR_OP_WIDTH   = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst,
  riscv_str_ops_arb_if.slave bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;
  localparam logic [7:0] TO_CNT  = 8'(TIMEOUT_CYCLES);

  logic [1:0]              state_q, state_d;
  logic [7:0]              cnt_q, cnt_d;
  logic                    last_q, last_d;
  logic                    owner_q, owner_d;
  logic [STR_OP_WIDTH-1:0] op_q, op_d;
  logic [31:0]             operand_q, operand_d;
  logic [31:0]             res_q, res_d;
  logic                    err_q, err_d;

  logic [1:0] req_v, gnt, rvalid;
  logic       win, unit_act, owner_rready;

  assign req_v        = {bus.req1_valid_i, bus.req0_valid_i};
  // On a tie the requester not granted last wins; otherwise the sole valid one.
  assign win          = (&req_v) ? ~last_q : req_v[1];
  assign unit_act     = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign owner_rready = owner_q ? bus.req1_rready_i : bus.req0_rready_i;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    owner_d   = owner_q;
    op_d      = op_q;
    operand_d = operand_q;
    res_d     = res_q;
    err_d     = err_q;
    gnt       = 2'b00;
    case (state_q)
      S_IDLE: begin
        if (|req_v && !rst) begin
          gnt[win]  = 1'b1;
          last_d    = win;
          owner_d   = win;
          op_d      = win ? bus.req1_op_i : bus.req0_op_i;
          operand_d = win ? bus.req1_operand_i : bus.req0_operand_i;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d = '0;
        if (bus.unit_ready_i) begin
          res_d   = bus.unit_result_i;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // Ready is checked first so a result landing on the timeout cycle is kept.
        if (bus.unit_ready_i) begin
          res_d   = bus.unit_result_i;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_RESP;
        end else if (cnt_q + 8'd1 == TO_CNT) begin
          res_d   = '0;
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        if (owner_rready) state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      last_q    <= 1'b1;
      owner_q   <= 1'b0;
      op_q      <= '0;
      operand_q <= '0;
      res_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      owner_q   <= owner_d;
      op_q      <= op_d;
      operand_q <= operand_d;
      res_q     <= res_d;
      err_q     <= err_d;
    end
  end

  assign rvalid = (state_q == S_RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;

  assign bus.req0_gnt_o      = gnt[0];
  assign bus.req1_gnt_o      = gnt[1];
  assign bus.req0_rvalid_o   = rvalid[0];
  assign bus.req1_rvalid_o   = rvalid[1];
  assign bus.req0_rdata_o    = rvalid[0] ? res_q : 32'd0;
  assign bus.req1_rdata_o    = rvalid[1] ? res_q : 32'd0;
  assign bus.req0_err_o      = rvalid[0] & err_q;
  assign bus.req1_err_o      = rvalid[1] & err_q;
  assign bus.unit_enable_o   = unit_act;
  assign bus.unit_operator_o = unit_act ? op_q : '0;
  assign bus.unit_operand_o  = unit_act ? operand_q : 32'd0;
  assign bus.unit_ex_ready_o = unit_act & bus.unit_ready_i;
  assign bus.busy_o          = (state_q != S_IDLE);
endmodule

// File: doc/riscv_str_ops_arb.md
RISCV_STR_OPS_ARB -- requirements
Module: riscv_str_ops_arb

Interface
REQ-001 Parameter: STR_OP_WIDTH, default 2, width of the string-op operator code (matches riscv_defines).
REQ-002 Parameter: TIMEOUT_CYCLES, default 16, maximum WAIT cycles before abort; legal range 2..255.
REQ-003 Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 reqN_valid_i (N=0,1)  in  1  requester N has an op pending; held until granted.
REQ-007 reqN_op_i  in  STR_OP_WIDTH  operator (STR_OP_UPPER/LOWER/LEET/ROT13).
REQ-008 reqN_operand_i  in  32  packed 4-character operand.
REQ-009 reqN_gnt_o  out  1  one-cycle pulse; the op and operand are latched this cycle.
REQ-010 reqN_rvalid_o  out  1  result available for requester N.
REQ-011 reqN_rdata_o  out  32  result; 0 when rvalid is low.
REQ-012 reqN_err_o  out  1  qualifies rvalid; 1 = timeout abort.
REQ-013 reqN_rready_i  in  1  requester accepts the result.
REQ-014 unit_enable_o  out  1  enable to the string-op unit.
REQ-015 unit_operator_o  out  STR_OP_WIDTH  latched operator.
REQ-016 unit_operand_o  out  32  latched operand.
REQ-017 unit_result_i  in  32  unit result.
REQ-018 unit_ready_i  in  1  unit result valid / unit done.
REQ-019 unit_ex_ready_o  out  1  release pulse telling the unit to leave its finish state.
REQ-020 busy_o  out  1  high in any state other than IDLE.

Function
REQ-021 FSM states: IDLE, ISSUE, WAIT, RESP.
REQ-022 IDLE with any reqN_valid_i high:
  - pulse gnt_o of the arbitration winner (combinational, same cycle);
  - latch op, operand and owner id;
  - go to ISSUE.
REQ-023 Arbitration is round-robin:
  - only one valid: that requester wins;
  - both valid: the requester that was not granted last wins;
  - last_grant updates on every grant.
REQ-024 ISSUE:
  - unit_enable_o=1 with the latched operator and operand;
  - unit_ready_i=1: capture unit_result_i, pulse unit_ex_ready_o, go to RESP (single-cycle ops, 1-cycle issue latency);
  - otherwise go to WAIT.
REQ-025 WAIT:
  - unit_enable_o stays 1 and the timeout counter increments each cycle;
  - unit_ready_i=1: capture the result, pulse unit_ex_ready_o, clear the counter, go to RESP.
REQ-026 Timeout: counter reaches TIMEOUT_CYCLES with unit_ready_i low -> go to RESP with rdata=0 and err=1; unit_ex_ready_o is not pulsed.
REQ-027 Simultaneous unit_ready_i and timeout in the same cycle: ready wins, err=0.
REQ-028 RESP:
  - owner's rvalid_o=1 with rdata/err held stable;
  - rready_i=1: go to IDLE;
  - no grant in the same cycle, so minimum back-to-back spacing is 3 cycles for single-cycle ops.
REQ-029 Outside ISSUE/WAIT: unit_enable_o=0, unit_operator_o/unit_operand_o=0, unit_ex_ready_o=0.
REQ-030 At most one gnt_o and at most one rvalid_o is high in any cycle; the non-owner's rvalid_o, rdata_o and err_o are 0.
REQ-031 A requester's valid_i dropping before grant is legal; the request is simply not served.
REQ-032 Leet-style ops (ready low through 3 step cycles, then high) give total latency grant->rvalid = 5 cycles.

Reset
REQ-033 rst=1 at a clock edge forces IDLE, counter=0, last_grant=1 (req0 wins the first tie), all latches=0.
REQ-034 All outputs read 0 in the cycle after a reset edge.
REQ-035 Reset mid-operation (ISSUE/WAIT/RESP) discards the in-flight op: no rvalid_o and no unit_ex_ready_o pulse afterwards.

Verification
REQ-036 Single UPPER from req0, operand 0x61626364, unit ready=1 in ISSUE with result 0x41424344 -> gnt0 pulse at T0, unit_enable at T1, rvalid0=1, rdata0=0x41424344, err0=0 at T2.
REQ-037 Both valid in IDLE after reset -> req0 granted first; both remain valid -> req1 granted next; grants alternate 0,1,0,1.
REQ-038 LEET op, unit ready low for 3 cycles then high with 0x31333337 -> unit_ex_ready_o single pulse; rvalid at grant+5; rdata=0x31333337.
REQ-039 Unit ready held low, TIMEOUT_CYCLES=16 -> RESP after 16 WAIT cycles, rdata=0, err=1; next request proceeds normally.
REQ-040 rst asserted during WAIT -> busy_o=0, unit_enable_o=0 next cycle, no rvalid ever seen for that op.
REQ-041 rready held low for 10 cycles in RESP with req1 valid -> rdata stable, no gnt1 until the cycle after rready.
